cm0ik_ahb_decoder_mux: RTL and testbench

AHB-Lite address decoder, response multiplexer and default slave for the Cortex-M0 subsystem bus. It sits between the processor master port and three AHB-Lite slaves: slot 0 ROM, slot 1 SRAM bridge, slot 2 peripheral bridge. It generates per-slave HSEL and the system HREADY, and returns the data-phase slave's HRDATA/HRESP to the master. Accesses to unmapped space are answered by an internal default slave with the two-cycle AHB ERROR response.

---
 rtl/cm0ik_ahb_decoder_mux_if.sv | 32 +++
 rtl/cm0ik_ahb_decoder_mux.sv | 90 +++++++++
 tb/tb_cm0ik_ahb_decoder_mux.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cm0ik_ahb_decoder_mux_if.sv
// Bus bundle between the Cortex-M0 master port, the decoder/mux and the three AHB-Lite slaves.
interface cm0ik_ahb_decoder_mux_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HSEL_S0, HSEL_S1, HSEL_S2;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2;
  logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2;
  logic        HRESP_S0, HRESP_S1, HRESP_S2;

  // Decoder view: takes the master address phase and slave responses.
  modport slave (
    input  HADDR, HTRANS,
    input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2,
    input  HRDATA_S0, HRDATA_S1, HRDATA_S2,
    input  HRESP_S0, HRESP_S1, HRESP_S2,
    output HSEL_S0, HSEL_S1, HSEL_S2,
    output HREADY, HRDATA, HRESP
  );

  // Bus-side view: master address phase plus the slave response sources.
  modport master (
    output HADDR, HTRANS,
    output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2,
    output HRDATA_S0, HRDATA_S1, HRDATA_S2,
    output HRESP_S0, HRESP_S1, HRESP_S2,
    input  HSEL_S0, HSEL_S1, HSEL_S2,
    input  HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/cm0ik_ahb_decoder_mux.sv
// AHB-Lite address decoder, data-phase response mux and ERROR-only default slave.
module cm0ik_ahb_decoder_mux #(
  parameter logic [31:0] S0_BASE     = 32'h0000_0000,
  parameter logic [31:0] S1_BASE     = 32'h2000_0000,
  parameter logic [31:0] S2_BASE     = 32'h4000_0000,
  parameter logic [31:0] REGION_MASK = 32'hE000_0000
) (
  input logic HCLK,
  input logic HRESET,
  cm0ik_ahb_decoder_mux_if.slave bus
);
  localparam int NUM_SLV = 3;
  localparam logic [NUM_SLV-1:0][31:0] BASES = {S2_BASE, S1_BASE, S0_BASE};

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} dflt_st_e;

  logic [NUM_SLV-1:0]        hit, s_ready, s_resp;
  logic [NUM_SLV-1:0][31:0]  s_rdata;
  logic                      dflt_hit;
  logic [NUM_SLV:0]          dsel;   // one-hot, top bit = default slave
  dflt_st_e                  st, st_nxt;
  logic                      dflt_ready, dflt_resp;
  logic                      hready, hresp;
  logic [31:0]               hrdata;
  logic                      unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];

  assign s_ready = {bus.HREADYOUT_S2, bus.HREADYOUT_S1, bus.HREADYOUT_S0};
  assign s_resp  = {bus.HRESP_S2, bus.HRESP_S1, bus.HRESP_S0};
  assign s_rdata = {bus.HRDATA_S2, bus.HRDATA_S1, bus.HRDATA_S0};

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_dec
    assign hit[g] = (bus.HADDR & REGION_MASK) == BASES[g];
  end
  assign dflt_hit = ~|hit;

  assign bus.HSEL_S0 = hit[0];
  assign bus.HSEL_S1 = hit[1];
  assign bus.HSEL_S2 = hit[2];

  // dsel only moves on accepted address phases, so a stalled data phase keeps its slave.
  always_ff @(posedge HCLK) begin
    if (HRESET)      dsel <= {1'b1, {NUM_SLV{1'b0}}};
    else if (hready) dsel <= {dflt_hit, hit};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) st <= ST_OKAY;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_OKAY: if (hready && bus.HTRANS[1] && dflt_hit) st_nxt = ST_ERR1;
      ST_ERR1: st_nxt = ST_ERR2;
      ST_ERR2: st_nxt = (bus.HTRANS[1] && dflt_hit) ? ST_ERR1 : ST_OKAY;
      default: st_nxt = ST_OKAY;
    endcase
  end

  always_comb begin
    dflt_ready = 1'b1;
    dflt_resp  = 1'b0;
    case (st)
      ST_ERR1: begin dflt_ready = 1'b0; dflt_resp = 1'b1; end
      ST_ERR2: begin dflt_ready = 1'b1; dflt_resp = 1'b1; end
      default: ;
    endcase
  end

  // Default slave drives the response unless a real slave owns the data phase.
  always_comb begin
    hready = dflt_ready;
    hresp  = dflt_resp;
    hrdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dsel[i]) begin
        hready = s_ready[i];
        hresp  = s_resp[i];
        hrdata = s_rdata[i];
      end
    end
  end

  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = hrdata;
endmodule

// File: tb/tb_cm0ik_ahb_decoder_mux.sv
// Directed scenario tables plus randomized traffic against a transfer-level reference model.
module tb_cm0ik_ahb_decoder_mux;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  cm0ik_ahb_decoder_mux_if bus();

  cm0ik_ahb_decoder_mux dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

  logic        rdy [3];
  logic        rsp [3];
  logic [31:0] rd  [3];
  assign bus.HREADYOUT_S0 = rdy[0];
  assign bus.HREADYOUT_S1 = rdy[1];
  assign bus.HREADYOUT_S2 = rdy[2];
  assign bus.HRESP_S0 = rsp[0];
  assign bus.HRESP_S1 = rsp[1];
  assign bus.HRESP_S2 = rsp[2];
  assign bus.HRDATA_S0 = rd[0];
  assign bus.HRDATA_S1 = rd[1];
  assign bus.HRDATA_S2 = rd[2];

  logic [2:0] sel_o;
  assign sel_o = {bus.HSEL_S2, bus.HSEL_S1, bus.HSEL_S0};

  int total = 0;
  int bad = 0;

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  t;
    logic        s2r;
    logic [2:0]  sel;
    logic        rdy;
    logic        rsp;
    logic [31:0] d;
  } vec_t;

  // Reference model: which target owns the current data phase (3 = unmapped)
  // and how many ERROR cycles are left for it (2, 1 or 0).
  int m_tgt = 3;
  int m_err = 0;

  function automatic int dec(input logic [31:0] a);
    int r;
    r = int'(a >> 29);
    return (r < 3) ? r : 3;
  endfunction

  function automatic logic exp_ready();
    if (m_tgt == 3) return (m_err != 2);
    return rdy[m_tgt];
  endfunction

  function automatic logic exp_resp();
    if (m_tgt == 3) return (m_err != 0);
    return rsp[m_tgt];
  endfunction

  function automatic logic [31:0] exp_data();
    if (m_tgt == 3) return 32'h0;
    return rd[m_tgt];
  endfunction

  function automatic logic [2:0] exp_sel();
    int d;
    d = dec(bus.HADDR);
    return (d == 3) ? 3'b000 : 3'(1 << d);
  endfunction

  // Advance one clock, updating the model from the inputs seen before the edge.
  task automatic tick();
    logic r;
    r = exp_ready();
    if (HRESET) begin
      m_tgt = 3; m_err = 0;
    end else if (r) begin
      m_tgt = dec(bus.HADDR);
      m_err = (m_tgt == 3 && bus.HTRANS[1]) ? 2 : 0;
    end else if (m_err == 2) begin
      m_err = 1;
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    bus.HADDR = 32'h6000_0000; bus.HTRANS = ID;
    tick(); tick();
    HRESET = 1'b0;
    @(negedge HCLK);
    total++;
    if ({bus.HREADY, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_state got rdy=%b resp=%b data=%h want 1 0 0", bus.HREADY, bus.HRESP, bus.HRDATA);
    end
    tick();
    bus.HADDR = 32'h2000_0004; bus.HTRANS = NS; rdy[1] = 1'b0;
    tick();
    bus.HADDR = 32'h6000_0000; bus.HTRANS = ID;
    @(negedge HCLK);
    total++;
    if ({bus.HREADY, bus.HRESP, bus.HRDATA} !== {1'b0, 1'b0, 32'hB1B1_B1B1}) begin
      bad++; $display("FAIL reset_stall got rdy=%b resp=%b data=%h want 0 0 b1b1b1b1", bus.HREADY, bus.HRESP, bus.HRDATA);
    end
    HRESET = 1'b1;
    tick();
    @(negedge HCLK);
    total++;
    if ({bus.HREADY, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_mid1 got rdy=%b resp=%b data=%h want 1 0 0", bus.HREADY, bus.HRESP, bus.HRDATA);
    end
    tick();
    HRESET = 1'b0;
    @(negedge HCLK);
    total++;
    if ({bus.HREADY, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_mid2 got rdy=%b resp=%b data=%h want 1 0 0", bus.HREADY, bus.HRESP, bus.HRDATA);
    end
    tick();
    rdy[1] = 1'b1;
  endtask

  task automatic test_decode();
    vec_t v [7] = '{
      '{32'h0000_0100, NS, 1'b1, 3'b001, 1'b1, 1'b0, 32'h0},
      '{32'h2000_0004, NS, 1'b1, 3'b010, 1'b1, 1'b0, 32'hA0A0_A0A0},
      '{32'h4000_0010, NS, 1'b1, 3'b100, 1'b1, 1'b0, 32'hB1B1_B1B1},
      '{32'h6000_0000, NS, 1'b1, 3'b000, 1'b1, 1'b0, 32'hC2C2_C2C2},
      '{32'h6000_0000, ID, 1'b1, 3'b000, 1'b0, 1'b1, 32'h0},
      '{32'h6000_0000, ID, 1'b1, 3'b000, 1'b1, 1'b1, 32'h0},
      '{32'h6000_0000, ID, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0}};
    foreach (v[i]) begin
      bus.HADDR = v[i].a; bus.HTRANS = v[i].t; rdy[2] = v[i].s2r;
      @(negedge HCLK);
      total++;
      if ({sel_o, bus.HREADY, bus.HRESP, bus.HRDATA} !== {v[i].sel, v[i].rdy, v[i].rsp, v[i].d}) begin
        bad++; $display("FAIL decode[%0d] got sel=%b rdy=%b resp=%b data=%h want sel=%b rdy=%b resp=%b data=%h",
          i, sel_o, bus.HREADY, bus.HRESP, bus.HRDATA, v[i].sel, v[i].rdy, v[i].rsp, v[i].d);
      end
      tick();
    end
  endtask

  task automatic test_unmapped();
    vec_t v [4] = '{
      '{32'h8000_0000, NS, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0},
      '{32'h8000_0000, ID, 1'b1, 3'b000, 1'b0, 1'b1, 32'h0},
      '{32'h8000_0000, ID, 1'b1, 3'b000, 1'b1, 1'b1, 32'h0},
      '{32'h8000_0000, ID, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0}};
    foreach (v[i]) begin
      bus.HADDR = v[i].a; bus.HTRANS = v[i].t; rdy[2] = v[i].s2r;
      @(negedge HCLK);
      total++;
      if ({sel_o, bus.HREADY, bus.HRESP, bus.HRDATA} !== {v[i].sel, v[i].rdy, v[i].rsp, v[i].d}) begin
        bad++; $display("FAIL unmapped[%0d] got sel=%b rdy=%b resp=%b data=%h want sel=%b rdy=%b resp=%b data=%h",
          i, sel_o, bus.HREADY, bus.HRESP, bus.HRDATA, v[i].sel, v[i].rdy, v[i].rsp, v[i].d);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [6] = '{
      '{32'hA000_0000, NS, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0},
      '{32'hA000_0004, NS, 1'b1, 3'b000, 1'b0, 1'b1, 32'h0},
      '{32'hA000_0004, NS, 1'b1, 3'b000, 1'b1, 1'b1, 32'h0},
      '{32'hA000_0004, ID, 1'b1, 3'b000, 1'b0, 1'b1, 32'h0},
      '{32'hA000_0004, ID, 1'b1, 3'b000, 1'b1, 1'b1, 32'h0},
      '{32'hA000_0004, ID, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0}};
    foreach (v[i]) begin
      bus.HADDR = v[i].a; bus.HTRANS = v[i].t; rdy[2] = v[i].s2r;
      @(negedge HCLK);
      total++;
      if ({sel_o, bus.HREADY, bus.HRESP, bus.HRDATA} !== {v[i].sel, v[i].rdy, v[i].rsp, v[i].d}) begin
        bad++; $display("FAIL back_to_back[%0d] got sel=%b rdy=%b resp=%b data=%h want sel=%b rdy=%b resp=%b data=%h",
          i, sel_o, bus.HREADY, bus.HRESP, bus.HRDATA, v[i].sel, v[i].rdy, v[i].rsp, v[i].d);
      end
      tick();
    end
  endtask

  task automatic test_wait_state();
    vec_t v [7] = '{
      '{32'h4000_0010, NS, 1'b1, 3'b100, 1'b1, 1'b0, 32'h0},
      '{32'h2000_0004, NS, 1'b0, 3'b010, 1'b0, 1'b0, 32'hC2C2_C2C2},
      '{32'h2000_0004, NS, 1'b0, 3'b010, 1'b0, 1'b0, 32'hC2C2_C2C2},
      '{32'h2000_0004, NS, 1'b0, 3'b010, 1'b0, 1'b0, 32'hC2C2_C2C2},
      '{32'h2000_0004, NS, 1'b1, 3'b010, 1'b1, 1'b0, 32'hC2C2_C2C2},
      '{32'h6000_0000, ID, 1'b1, 3'b000, 1'b1, 1'b0, 32'hB1B1_B1B1},
      '{32'h6000_0000, ID, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0}};
    foreach (v[i]) begin
      bus.HADDR = v[i].a; bus.HTRANS = v[i].t; rdy[2] = v[i].s2r;
      @(negedge HCLK);
      total++;
      if ({sel_o, bus.HREADY, bus.HRESP, bus.HRDATA} !== {v[i].sel, v[i].rdy, v[i].rsp, v[i].d}) begin
        bad++; $display("FAIL wait_state[%0d] got sel=%b rdy=%b resp=%b data=%h want sel=%b rdy=%b resp=%b data=%h",
          i, sel_o, bus.HREADY, bus.HRESP, bus.HRDATA, v[i].sel, v[i].rdy, v[i].rsp, v[i].d);
      end
      tick();
    end
  endtask

  task automatic test_unmapped_idle();
    vec_t v [3] = '{
      '{32'hE000_0000, ID, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0},
      '{32'hE000_0000, ID, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0},
      '{32'hE000_0000, 2'b01, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0}};
    foreach (v[i]) begin
      bus.HADDR = v[i].a; bus.HTRANS = v[i].t; rdy[2] = v[i].s2r;
      @(negedge HCLK);
      total++;
      if ({sel_o, bus.HREADY, bus.HRESP, bus.HRDATA} !== {v[i].sel, v[i].rdy, v[i].rsp, v[i].d}) begin
        bad++; $display("FAIL unmapped_idle[%0d] got sel=%b rdy=%b resp=%b data=%h want sel=%b rdy=%b resp=%b data=%h",
          i, sel_o, bus.HREADY, bus.HRESP, bus.HRDATA, v[i].sel, v[i].rdy, v[i].rsp, v[i].d);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [2:0]  e_sel;
    logic        e_rdy, e_rsp;
    logic [31:0] e_d;
    for (int c = 0; c < 400; c++) begin
      bus.HADDR  = {3'($urandom_range(7)), 29'($urandom)};
      bus.HTRANS = 2'($urandom);
      HRESET     = ($urandom_range(63) == 0);
      for (int s = 0; s < 3; s++) begin
        rdy[s] = ($urandom_range(3) != 0);
        rsp[s] = ($urandom_range(7) == 0);
        rd[s]  = $urandom;
      end
      @(negedge HCLK);
      e_sel = exp_sel(); e_rdy = exp_ready(); e_rsp = exp_resp(); e_d = exp_data();
      total++;
      if ({sel_o, bus.HREADY, bus.HRESP, bus.HRDATA} !== {e_sel, e_rdy, e_rsp, e_d}) begin
        bad++; $display("FAIL random[%0d] got sel=%b rdy=%b resp=%b data=%h want sel=%b rdy=%b resp=%b data=%h",
          c, sel_o, bus.HREADY, bus.HRESP, bus.HRDATA, e_sel, e_rdy, e_rsp, e_d);
      end
      tick();
    end
    HRESET = 1'b0;
  endtask

  initial begin
    bus.HADDR = 32'h6000_0000;
    bus.HTRANS = ID;
    for (int s = 0; s < 3; s++) begin rdy[s] = 1'b1; rsp[s] = 1'b0; end
    rd[0] = 32'hA0A0_A0A0; rd[1] = 32'hB1B1_B1B1; rd[2] = 32'hC2C2_C2C2;
    #1;
    test_reset();
    test_decode();
    test_unmapped();
    test_back_to_back();
    test_wait_state();
    test_unmapped_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
